ativiade5_mem_stream_reader: RTL and testbench
==============================================

Name: ativiade5_mem_stream_reader

Overview:
- Avalon-MM read master that sits directly upstream of the 32-bit single-port on-chip RAM (17-bit word address, 1-cycle read latency, unregistered q).
- On a start command it reads a contiguous word region and emits it as an Avalon-ST packet with full backpressure support.
- Outstanding reads are credit-limited so that no returned word is ever dropped; a small skid FIFO absorbs the fixed RAM latency.

Parameters:
- ADDR_W, 17, RAM word-address width.
- DATA_W, 32, RAM/stream data width.
- MEM_WORDS, 89325, RAM depth; address wraps to 0 after MEM_WORDS-1.
- LEN_W, 18, width of the length field (max packet 2^18-1 words).
- FIFO_DEPTH, 4, skid FIFO entries; power of 2, minimum 4.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; honoured only in IDLE.
- base_addr  in  ADDR_W  first word address, sampled with start.
- length  in  LEN_W  word count, sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- mem_address  out  ADDR_W  RAM word address.
- mem_chipselect  out  1  read issue qualifier.
- mem_write  out  1  tied 0.
- mem_byteenable  out  4  tied 4'hF.
- mem_clken  out  1  tied 1.
- mem_readdata  in  DATA_W  RAM q, valid 1 cycle after an issued address.
- src_data  out  DATA_W  stream payload.
- src_valid  out  1  stream valid.
- src_ready  in  1  stream ready; transfer = valid & ready.
- src_startofpacket  out  1  high with the first word.
- src_endofpacket  out  1  high with the last word.

Behaviour:
- Reset: busy=0, done=0, src_valid=0, sop=0, eop=0, mem_chipselect=0, mem_address=0. FIFO emptied, counters and in-flight flag cleared, FSM in IDLE.
- Reset mid-operation aborts immediately. Any in-flight RAM return is discarded. No done pulse is produced.
- FSM states and transitions:
  - IDLE: start with length!=0 -> RUN; start with length==0 -> DONE.
  - RUN: issue reads; after the last issue -> DRAIN.
  - DRAIN: wait until in-flight=0, FIFO empty and the last word is accepted -> DONE.
  - DONE: done=1 for 1 cycle -> IDLE.
- start is ignored outside IDLE.
- Issue rule: a read is issued in a cycle (mem_chipselect=1, registered address) only if in RUN and (fifo_count + inflight) < FIFO_DEPTH. inflight is 0 or 1.
- Return: the cycle after an issue, mem_readdata is written into the FIFO unconditionally. The credit rule guarantees space.
- Address increments by 1 per issue; MEM_WORDS-1 is followed by 0. The wrap uses a compare, not a modulo.
- issued counter (LEN_W) counts up to length. The sent counter tracks stream transfers; sop is asserted when sent==0 and eop when sent==length-1.
- sop/eop travel with the FIFO head, derived from sent. They are not stored in the FIFO.
- Latency: start accepted at edge N -> first issue in cycle N+1 -> FIFO write at end of N+2 -> src_valid in cycle N+3.
- Throughput: with src_ready held high, one word per cycle sustained after the first word.
- Stream rules:
  - src_valid, once high, stays high with stable data until accepted.
  - src_ready low simply stalls issue once credits are exhausted.
  - Simultaneous FIFO push and pop in one cycle is legal; count is unchanged.
- done asserts the cycle after the transfer carrying eop; busy deasserts in that same cycle.

Decomposition:
- Shared package ativiade5_stream_pkg:
  - FSM state enum {IDLE, RUN, DRAIN, DONE}.
  - ADDR_W, DATA_W and MEM_WORDS constants, shared with the RAM wrapper.
- Sub-module ativiade5_stream_fifo:
  - Synchronous show-ahead FIFO, depth FIFO_DEPTH.
  - Ports: push, pop, din, dout, empty, count.
  - Synchronous reset.

Test Plan:
- RAM preloaded mem[a]=a^32'hA5A50000; start base=0x10 length=5, src_ready=1 -> words 0xA5A50010..0xA5A50014 on consecutive cycles starting at N+3; sop on first, eop on fifth; done pulse 1 cycle after; busy low thereafter.
- Same as above with src_ready toggling 1,0,0,1,… -> identical data order; never more than 4 words buffered; no mem_chipselect while credits=0; no lost or duplicated words.
- Wrap: base=89323 length=4 -> mem_address sequence 89323, 89324, 0, 1; data matches; eop on the 4th word.
- length=0 -> no mem_chipselect, no src_valid, done pulse on the cycle after start.
- start pulsed again during RUN with different base/length -> ignored; the original packet completes unchanged.
- reset asserted mid-packet (after 2 of 8 words) -> next cycle all outputs at reset values; the new start base=0 length=2 produces exactly 2 correct words with fresh sop/eop.

Source files
------------

// File: rtl/ativiade5_stream_pkg.sv
// Shared types and RAM geometry for the memory-to-stream reader and its RAM wrapper.
package ativiade5_stream_pkg;
    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 32;
    localparam int MEM_WORDS = 89325;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/ativiade5_mem_stream_reader_if.sv
// RAM read port plus Avalon-ST source, bundled as one bus; master = reader side.
interface ativiade5_mem_stream_reader_if #(
    parameter int ADDR_W = ativiade5_stream_pkg::ADDR_W,
    parameter int DATA_W = ativiade5_stream_pkg::DATA_W
) ();
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_startofpacket;
    logic              src_endofpacket;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        input  mem_readdata,
        output src_data, src_valid, src_startofpacket, src_endofpacket,
        input  src_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        output mem_readdata,
        input  src_data, src_valid, src_startofpacket, src_endofpacket,
        output src_ready
    );
endinterface

// File: rtl/ativiade5_stream_fifo.sv
// Show-ahead skid FIFO: head word is visible on dout whenever empty is low.
module ativiade5_stream_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic [PTR_W:0]    count
);
    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != (PTR_W+1)'(DEPTH)) || do_pop);

    // Storage carries no reset so it can map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = mem_reg[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign count = count_reg;
endmodule

// File: rtl/ativiade5_mem_stream_reader.sv
// Reads a contiguous RAM region and emits it as one Avalon-ST packet; reads are
// credit-limited against the skid FIFO so a returning word always has a slot.
module ativiade5_mem_stream_reader #(
    parameter int ADDR_W     = ativiade5_stream_pkg::ADDR_W,
    parameter int DATA_W     = ativiade5_stream_pkg::DATA_W,
    parameter int MEM_WORDS  = ativiade5_stream_pkg::MEM_WORDS,
    parameter int LEN_W      = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LEN_W-1:0]      length,
    output logic                  busy,
    output logic                  done,
    ativiade5_mem_stream_reader_if.master bus
);
    import ativiade5_stream_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  issued_reg;
    logic [LEN_W-1:0]  sent_reg;
    logic              inflight_reg;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              fire;
    logic              last_issue;
    logic              last_sent;

    // A word already in flight still needs its FIFO slot, so it counts as used.
    assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};
    assign issue      = (state_reg == RUN) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign fire       = !fifo_empty && bus.src_ready;
    assign last_issue = (issued_reg == len_reg - 1'b1);
    assign last_sent  = (sent_reg == len_reg - 1'b1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = (length == '0) ? DONE : RUN;
            RUN:   if (issue && last_issue) state_next = DRAIN;
            DRAIN: if (fire && last_sent && !inflight_reg) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            len_reg      <= '0;
            issued_reg   <= '0;
            sent_reg     <= '0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= issue;
            if (state_reg == IDLE && start) begin
                addr_reg   <= base_addr;
                len_reg    <= length;
                issued_reg <= '0;
                sent_reg   <= '0;
            end else begin
                if (issue) begin
                    addr_reg   <= (addr_reg == ADDR_W'(MEM_WORDS - 1)) ? '0 : addr_reg + 1'b1;
                    issued_reg <= issued_reg + 1'b1;
                end
                if (fire) sent_reg <= sent_reg + 1'b1;
            end
        end
    end

    // RAM q is valid exactly one cycle after an issue; the credit check guarantees room.
    ativiade5_stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_reg),
        .pop   (fire),
        .din   (bus.mem_readdata),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy = (state_reg == RUN) || (state_reg == DRAIN);
    assign done = (state_reg == DONE);

    assign bus.mem_address       = addr_reg;
    assign bus.mem_chipselect    = issue;
    assign bus.mem_write         = 1'b0;
    assign bus.mem_byteenable    = 4'hF;
    assign bus.mem_clken         = 1'b1;
    assign bus.src_data          = fifo_dout;
    assign bus.src_valid         = !fifo_empty;
    // Packet markers follow the FIFO head and are masked while nothing is presented.
    assign bus.src_startofpacket = !fifo_empty && (sent_reg == '0);
    assign bus.src_endofpacket   = !fifo_empty && last_sent;
endmodule

// File: tb/tb_ativiade5_mem_stream_reader.sv
// Scoreboard bench: stimulus pushes expected addresses/beats, a negedge monitor pops and compares.
module tb_ativiade5_mem_stream_reader;
    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 32;
    localparam int MEM_WORDS = 89325;
    localparam int LEN_W     = 18;
    localparam int DEPTH     = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  length = '0;
    logic              busy;
    logic              done;

    ativiade5_mem_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ativiade5_mem_stream_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS),
        .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .bus(bus.master)
    );

    always #5 clk = ~clk;

    // RAM model: preloaded contents mem[a] = a ^ 32'hA5A50000, one-cycle registered q.
    always @(posedge clk) bus.mem_readdata <= 32'(bus.mem_address) ^ 32'hA5A50000;

    typedef struct { logic [31:0] data; logic sop; logic eop; } beat_t;
    beat_t       exp_q[$];
    int unsigned addr_q[$];
    int tests = 0;
    int fails = 0;
    int cs_total = 0;
    int acc_total = 0;
    int ready_mode = 0;
    logic zero_start_ok = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got event expected none at %0t", name, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: packet of len words from base, addresses wrapping modulo the RAM depth.
    task automatic start_pkt(input int unsigned base, input int unsigned len);
        for (int i = 0; i < int'(len); i++) begin
            beat_t b;
            int unsigned a;
            a = (base + i) % MEM_WORDS;
            addr_q.push_back(a);
            b.data = a ^ 32'hA5A50000;
            b.sop  = (i == 0);
            b.eop  = (i == int'(len) - 1);
            exp_q.push_back(b);
        end
        $display("[TB] start base=%0d length=%0d", base, len);
        base_addr = ADDR_W'(base);
        length    = LEN_W'(len);
        start     = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (done) break;
            cyc();
        end
        if (i == 3000) begin
            fail_now("done_timeout");
        end else begin
            check("busy_at_done", busy, 0);
        end
        cyc();
        check("busy_after_done", busy, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int ph = 0;
        bus.src_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.src_ready = 1'b1;
                1:       bus.src_ready = (ph % 3 == 0);
                default: bus.src_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    // Monitor: compare issues, beats, done pulses and backpressure stability.
    initial begin
        logic done_pend = 1'b0;
        logic prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                addr_q.delete();
                done_pend = 1'b0;
                prev_stall = 1'b0;
                cs_total = 0;
                acc_total = 0;
            end else begin
                logic next_pend;
                if (done || done_pend) check("done_pulse", done, done_pend);
                if (prev_stall) begin
                    check("hold_valid", bus.src_valid, 1);
                    check("hold_data", bus.src_data, prev_data);
                end
                if (bus.mem_chipselect) begin
                    check("credit_limit", (cs_total - acc_total) < DEPTH, 1);
                    if (addr_q.size() == 0) fail_now("unexpected_issue");
                    else check("mem_address", bus.mem_address, addr_q.pop_front());
                    cs_total++;
                end
                next_pend = start && (length == 0) && zero_start_ok;
                if (bus.src_valid && bus.src_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_word");
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("src_data", bus.src_data, e.data);
                        check("src_sop", bus.src_startofpacket, e.sop);
                        check("src_eop", bus.src_endofpacket, e.eop);
                        $display("[TB] beat data=%h sop=%0b eop=%0b", bus.src_data,
                                 bus.src_startofpacket, bus.src_endofpacket);
                        next_pend = next_pend | e.eop;
                    end
                    acc_total++;
                end
                done_pend  = next_pend;
                prev_stall = bus.src_valid && !bus.src_ready;
                prev_data  = bus.src_data;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, bus.src_valid, 0);
        check({tag, "_sop"}, bus.src_startofpacket, 0);
        check({tag, "_eop"}, bus.src_endofpacket, 0);
        check({tag, "_cs"}, bus.mem_chipselect, 0);
        check({tag, "_addr"}, bus.mem_address, 0);
    endtask

    initial begin
        int b0;
        int i;
        reset = 1'b1;
        repeat (3) cyc();
        check_reset_outputs("reset");
        check("tied_write", bus.mem_write, 0);
        check("tied_be", bus.mem_byteenable, 4'hF);
        reset = 1'b0;
        cyc();

        // Basic packet with fixed latency and full throughput.
        ready_mode = 0;
        start_pkt(32'h10, 5);
        check("busy_after_start", busy, 1);
        check("first_issue", bus.mem_chipselect, 1);
        cyc();
        check("valid_n2", bus.src_valid, 0);
        cyc();
        check("valid_n3", bus.src_valid, 1);
        check("first_data", bus.src_data, 32'hA5A50010);
        for (int k = 1; k < 5; k++) begin
            cyc();
            check("throughput_valid", bus.src_valid, 1);
        end
        wait_done();

        ready_mode = 1;
        start_pkt(32'h10, 5);
        wait_done();

        ready_mode = 2;
        start_pkt(89323, 4);
        wait_done();

        // Zero-length command: done only.
        ready_mode = 0;
        zero_start_ok = 1'b1;
        start_pkt(32'h20, 0);
        zero_start_ok = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        repeat (4) begin
            cyc();
            check("zero_no_valid", bus.src_valid, 0);
        end

        // A second start while running is ignored.
        ready_mode = 1;
        start_pkt(32'h100, 6);
        cyc();
        cyc();
        base_addr = ADDR_W'(32'h500);
        length    = LEN_W'(3);
        start     = 1'b1;
        cyc();
        start = 1'b0;
        wait_done();

        // Reset mid-packet after two accepted words.
        ready_mode = 0;
        b0 = acc_total;
        start_pkt(32'h40, 8);
        for (i = 0; i < 100 && (acc_total - b0) < 2; i++) cyc();
        if (i == 100) fail_now("midreset_timeout");
        reset = 1'b1;
        cyc();
        check_reset_outputs("midreset");
        reset = 1'b0;
        start_pkt(0, 2);
        wait_done();

        ready_mode = 2;
        for (int p = 0; p < 6; p++) begin
            int unsigned rb, rl;
            rb = (p % 2 == 0) ? $urandom_range(MEM_WORDS - 8, MEM_WORDS - 1)
                              : $urandom_range(0, MEM_WORDS - 1);
            rl = $urandom_range(1, 12);
            start_pkt(rb, rl);
            wait_done();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
